// File: rtl/id_decode_stage.sv
// RV32 instruction-decode stage: decodes a fetched instruction into the control
// bundle and holds it in a one-entry ID/EX register with valid/ready flow control.
module id_decode_stage #(
  parameter int XLEN        = 32,
  parameter bit ENABLE_M    = 1'b0,
  parameter bit ENABLE_JALR = 1'b1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [XLEN-1:0]  out_pc,
  output logic             out_regwrite,
  output logic             out_alusrc,
  output logic             out_memwrite,
  output logic             out_branch,
  output logic             out_jump,
  output logic             out_jalr,
  output logic             out_muldiv,
  output logic             out_illegal,
  output logic [2:0]       out_immsrc,
  output logic [1:0]       out_resultsrc,
  output logic [1:0]       out_aluop,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; the producer holds its payload stable until then, and out_* stay stable
  // while out_valid && !out_ready.
  logic accept;
  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // ctrl packs {regwrite, immsrc[2:0], alusrc, memwrite, resultsrc[1:0], branch, aluop[1:0], jump}
  logic [11:0] ctrl_raw, dec_ctrl;
  logic        jalr_raw, muldiv_raw, legal, dec_jalr, dec_muldiv, dec_illegal;
  logic [6:0]  opcode, funct7;

  assign opcode = in_instr[6:0];
  assign funct7 = in_instr[31:25];

  always_comb begin
    ctrl_raw   = '0;
    jalr_raw   = 1'b0;
    muldiv_raw = 1'b0;
    legal      = (in_instr[1:0] == 2'b11);
    case (opcode)
      7'b0110011: begin
        ctrl_raw = 12'b1_000_0_0_00_0_10_0;
        if (funct7 == 7'b0000001 && ENABLE_M) muldiv_raw = 1'b1;
        else if (funct7 != 7'b0000000 && funct7 != 7'b0100000) legal = 1'b0;
      end
      7'b0010011: ctrl_raw = 12'b1_000_1_0_00_0_10_0;
      7'b1100011: ctrl_raw = 12'b0_010_0_0_00_1_01_0;
      7'b0000011: ctrl_raw = 12'b1_000_1_0_01_0_00_0;
      7'b0100011: ctrl_raw = 12'b0_001_1_1_00_0_00_0;
      7'b1101111: ctrl_raw = 12'b1_011_0_0_10_0_00_1;
      7'b0110111: ctrl_raw = 12'b1_100_1_0_11_0_00_0;
      7'b0010111: ctrl_raw = 12'b1_100_0_0_11_0_00_0;
      7'b1100111: begin
        if (ENABLE_JALR) begin
          ctrl_raw = 12'b1_000_1_0_10_0_00_1;
          jalr_raw = 1'b1;
        end else begin
          legal = 1'b0;
        end
      end
      default: legal = 1'b0;
    endcase
  end

  // Illegal entries must carry no side effects downstream, so every control is squashed.
  assign dec_illegal = !legal;
  assign dec_ctrl    = legal ? ctrl_raw : 12'b0;
  assign dec_jalr    = legal && jalr_raw;
  assign dec_muldiv  = legal && muldiv_raw;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_instr     <= '0;
      out_pc        <= '0;
      out_regwrite  <= 1'b0;
      out_immsrc    <= '0;
      out_alusrc    <= 1'b0;
      out_memwrite  <= 1'b0;
      out_resultsrc <= '0;
      out_branch    <= 1'b0;
      out_aluop     <= '0;
      out_jump      <= 1'b0;
      out_jalr      <= 1'b0;
      out_muldiv    <= 1'b0;
      out_illegal   <= 1'b0;
      illegal_count <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid     <= 1'b1;
        out_instr     <= in_instr;
        out_pc        <= in_pc;
        out_regwrite  <= dec_ctrl[11];
        out_immsrc    <= dec_ctrl[10:8];
        out_alusrc    <= dec_ctrl[7];
        out_memwrite  <= dec_ctrl[6];
        out_resultsrc <= dec_ctrl[5:4];
        out_branch    <= dec_ctrl[3];
        out_aluop     <= dec_ctrl[2:1];
        out_jump      <= dec_ctrl[0];
        out_jalr      <= dec_jalr;
        out_muldiv    <= dec_muldiv;
        out_illegal   <= dec_illegal;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept && dec_illegal && illegal_count != CNT_MAX)
        illegal_count <= illegal_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_id_decode_stage.sv
// Bench for id_decode_stage: two instances with different parameter sets share one
// stimulus stream; per-instance expected queues are checked by a negedge monitor.
module tb_id_decode_stage;

  localparam int W = 87; // {instr[31:0], pc[31:0], ctrl[14:0], count[7:0]}
  localparam logic [14:0] ILL = 15'h4000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic [31:0] in_instr = '0, in_pc = '0;

  logic in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [31:0] out_instr_a, out_pc_a, out_instr_b, out_pc_b;
  logic rw_a, as_a, mw_a, br_a, jp_a, jr_a, md_a, il_a;
  logic rw_b, as_b, mw_b, br_b, jp_b, jr_b, md_b, il_b;
  logic [2:0] imm_a, imm_b;
  logic [1:0] rs_a, rs_b, op_a, op_b;
  logic [1:0] cnt_a;
  logic [7:0] cnt_b;
  logic [14:0] ctrl_a, ctrl_b;

  // ctrl order: {illegal, muldiv, jalr, regwrite, immsrc, alusrc, memwrite, resultsrc, branch, aluop, jump}
  assign ctrl_a = {il_a, md_a, jr_a, rw_a, imm_a, as_a, mw_a, rs_a, br_a, op_a, jp_a};
  assign ctrl_b = {il_b, md_b, jr_b, rw_b, imm_b, as_b, mw_b, rs_b, br_b, op_b, jp_b};

  logic [W-1:0] exp_qa[$];
  logic [W-1:0] exp_qb[$];
  int n_cmp = 0;
  int n_bad = 0;

  id_decode_stage #(.XLEN(32), .ENABLE_M(1'b0), .ENABLE_JALR(1'b1), .CNT_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_instr(out_instr_a), .out_pc(out_pc_a),
    .out_regwrite(rw_a), .out_alusrc(as_a), .out_memwrite(mw_a), .out_branch(br_a),
    .out_jump(jp_a), .out_jalr(jr_a), .out_muldiv(md_a), .out_illegal(il_a),
    .out_immsrc(imm_a), .out_resultsrc(rs_a), .out_aluop(op_a), .illegal_count(cnt_a));

  id_decode_stage #(.XLEN(32), .ENABLE_M(1'b1), .ENABLE_JALR(1'b0), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_instr(out_instr_b), .out_pc(out_pc_b),
    .out_regwrite(rw_b), .out_alusrc(as_b), .out_memwrite(mw_b), .out_branch(br_b),
    .out_jump(jp_b), .out_jalr(jr_b), .out_muldiv(md_b), .out_illegal(il_b),
    .out_immsrc(imm_b), .out_resultsrc(rs_b), .out_aluop(op_b), .illegal_count(cnt_b));

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: compare each entry as execute consumes it
  always @(negedge clk) begin
    if (rst_n && !flush && out_ready) begin
      if (out_valid_a) begin
        if (exp_qa.size() == 0) check("a_unexpected_entry", 1, 0);
        else check("a_entry", {out_instr_a, out_pc_a, ctrl_a, 6'b0, cnt_a}, exp_qa.pop_front());
      end
      if (out_valid_b) begin
        if (exp_qb.size() == 0) check("b_unexpected_entry", 1, 0);
        else check("b_entry", {out_instr_b, out_pc_b, ctrl_b, cnt_b}, exp_qb.pop_front());
      end
    end
  end

  // driver: present one instruction, wait for acceptance, push expectations
  task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                      input logic [14:0] ca, input logic [7:0] na,
                      input logic [14:0] cb, input logic [7:0] nb);
    int g = 0;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    #1;
    while (!(in_ready_a && in_ready_b) && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    check("send_ready", {in_ready_a, in_ready_b}, 2'b11);
    exp_qa.push_back({instr, pc, ca, na});
    exp_qb.push_back({instr, pc, cb, nb});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while ((exp_qa.size() != 0 || exp_qb.size() != 0) && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    check("drain_empty", {exp_qa.size() == 0, exp_qb.size() == 0}, 2'b11);
  endtask

  localparam logic [14:0] C_R     = 15'b0_0_0_1_000_0_0_00_0_10_0;
  localparam logic [14:0] C_I     = 15'b0_0_0_1_000_1_0_00_0_10_0;
  localparam logic [14:0] C_LW    = 15'b0_0_0_1_000_1_0_01_0_00_0;
  localparam logic [14:0] C_SW    = 15'b0_0_0_0_001_1_1_00_0_00_0;
  localparam logic [14:0] C_BEQ   = 15'b0_0_0_0_010_0_0_00_1_01_0;
  localparam logic [14:0] C_JAL   = 15'b0_0_0_1_011_0_0_10_0_00_1;
  localparam logic [14:0] C_LUI   = 15'b0_0_0_1_100_1_0_11_0_00_0;
  localparam logic [14:0] C_AUIPC = 15'b0_0_0_1_100_0_0_11_0_00_0;
  localparam logic [14:0] C_JALR  = 15'b0_0_1_1_000_1_0_10_0_00_1;
  localparam logic [14:0] C_MUL   = 15'b0_1_0_1_000_0_0_00_0_10_0;

  logic [31:0] stream_i [6] = '{32'h0000A083, 32'h00112023, 32'h00000063,
                                32'h000000EF, 32'h000010B7, 32'h00000097};
  logic [14:0] stream_c [6] = '{C_LW, C_SW, C_BEQ, C_JAL, C_LUI, C_AUIPC};

  initial begin
    // reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", {out_valid_a, out_valid_b}, 2'b00);
    check("reset_ctrl", {ctrl_a, ctrl_b}, 30'h0);
    check("reset_data", {out_instr_a, out_pc_a, out_instr_b, out_pc_b}, 128'h0);
    check("reset_count", {cnt_a, cnt_b}, 10'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", {in_ready_a, in_ready_b}, 2'b11);

    // add x1,x2,x3 then back-to-back stream
    send(32'h003100B3, 32'h00000100, C_R, 8'd0, C_R, 8'd0);
    check("add_latency_valid", {out_valid_a, out_valid_b}, 2'b11);
    for (int k = 0; k < 6; k++) begin
      send(stream_i[k], 32'h104 + 32'(4 * k), stream_c[k], 8'd0, stream_c[k], 8'd0);
      check("stream_no_bubble", {out_valid_a, out_valid_b}, 2'b11);
    end
    drain();

    // back-pressure for 3 cycles, then release and reload on the same edge
    out_ready = 1'b0;
    send(32'h00108093, 32'h00000120, C_I, 8'd0, C_I, 8'd0);
    for (int k = 0; k < 3; k++) begin
      check("stall_ready_low", {in_ready_a, in_ready_b}, 2'b00);
      check("stall_hold_a", {out_valid_a, out_instr_a, out_pc_a, ctrl_a}, {1'b1, 32'h00108093, 32'h120, C_I});
      check("stall_hold_b", {out_valid_b, out_instr_b, out_pc_b, ctrl_b}, {1'b1, 32'h00108093, 32'h120, C_I});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(32'h40208033, 32'h00000124, C_R, 8'd0, C_R, 8'd0);
    check("release_reload", {out_valid_a, out_instr_a, out_instr_b}, {1'b1, 32'h40208033, 32'h40208033});

    // jalr, mul, reserved funct7 across both parameter sets
    send(32'h000080E7, 32'h00000128, C_JALR, 8'd0, ILL, 8'd1);
    send(32'h02208033, 32'h0000012C, ILL, 8'd1, C_MUL, 8'd1);
    send(32'h04208033, 32'h00000130, ILL, 8'd2, ILL, 8'd2);
    drain();

    // flush kills a held entry and blocks acceptance
    out_ready = 1'b0;
    send(32'h00108093, 32'h00000140, C_I, 8'd2, C_I, 8'd2);
    flush = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h00000000;
    in_pc = 32'h00000144;
    #1;
    check("flush_ready_low", {in_ready_a, in_ready_b}, 2'b00);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_kills_valid", {out_valid_a, out_valid_b}, 2'b00);
    check("flush_count_kept", {cnt_a, cnt_b}, {2'd2, 8'd2});
    void'(exp_qa.pop_front());
    void'(exp_qb.pop_front());
    out_ready = 1'b1;

    // reset mid-operation drops the held entry and clears the counter
    out_ready = 1'b0;
    send(32'h00108093, 32'h00000150, C_I, 8'd2, C_I, 8'd2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midreset_valid", {out_valid_a, out_valid_b}, 2'b00);
    check("midreset_count", {cnt_a, cnt_b}, 10'h0);
    check("midreset_data", {out_instr_a, ctrl_a}, 47'h0);
    exp_qa.delete();
    exp_qb.delete();
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // counter saturation on the 2-bit instance
    send(32'h00000000, 32'h00000160, ILL, 8'd1, ILL, 8'd1);
    send(32'h00000000, 32'h00000164, ILL, 8'd2, ILL, 8'd2);
    send(32'h00000000, 32'h00000168, ILL, 8'd3, ILL, 8'd3);
    send(32'h00000000, 32'h0000016C, ILL, 8'd3, ILL, 8'd4);
    send(32'h00000000, 32'h00000170, ILL, 8'd3, ILL, 8'd5);
    drain();
    check("final_count", {cnt_a, cnt_b}, {2'd3, 8'd5});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_decode_stage.md
# id_decode_stage

Registered instruction-decode stage for the pipelined RV32 core: accepts a fetched instruction with valid/ready, decodes it into the standard control bundle, and holds the result in a one-entry ID/EX pipeline register. Supersedes the purely combinational main decoder. Adds JALR, optional M-extension detection, illegal-instruction flagging with a saturating counter, flush, and back-pressure. Sits between the IF/ID register and the execute stage.

## Interface
- XLEN, 32, width of PC path
- ENABLE_M, 0, 1 = R-type funct7 0000001 is legal and sets muldiv
- ENABLE_JALR, 1, 1 = opcode 1100111 decoded; 0 = treated as illegal
- CNT_W, 8, width of illegal_count
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset: synchronous, active-low
- in_valid  in  1  in_instr/in_pc valid
- in_ready  out  1  stage can accept this cycle (combinational)
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction PC
- flush  in  1  kill held entry, block acceptance
- out_valid  out  1  registered entry valid
- out_ready  in  1  execute consumes entry
- out_instr  out  32, out_pc  out  XLEN  registered copies
- out_regwrite, out_alusrc, out_memwrite, out_branch, out_jump, out_jalr, out_muldiv, out_illegal  out  1 each
- out_immsrc  out  3, out_resultsrc  out  2, out_aluop  out  2
- illegal_count  out  CNT_W  accepted illegal instructions, saturating

## Operation
- Accept = in_valid && in_ready. in_ready = !flush && (!out_valid || out_ready).
- Decode by opcode in_instr[6:0]; fields {regwrite, immsrc, alusrc, memwrite, resultsrc, branch, aluop, jump}; no don't-cares, unused fields are 0:
  - 0110011 R: 1_000_0_0_00_0_10_0
  - 0010011 I-ALU: 1_000_1_0_00_0_10_0
  - 1100011 B: 0_010_0_0_00_1_01_0
  - 0000011 load: 1_000_1_0_01_0_00_0
  - 0100011 store: 0_001_1_1_00_0_00_0
  - 1101111 JAL: 1_011_0_0_10_0_00_1
  - 0110111 LUI: 1_100_1_0_11_0_00_0
  - 0010111 AUIPC: 1_100_0_0_11_0_00_0
  - 1100111 JALR (ENABLE_JALR=1): 1_000_1_0_10_0_00_1, jalr=1
- jalr=1 only for JALR; muldiv=1 only for R-type with funct7=0000001 and ENABLE_M=1.
- Illegal when: in_instr[1:0]!=11; opcode not listed (or JALR with ENABLE_JALR=0); R-type funct7 not in {0000000, 0100000, 0000001 if ENABLE_M}. Illegal entries pass through with illegal=1 and all other control fields 0 (no write, branch, jump, or store side effects).
- illegal_count increments by 1 per accepted illegal instruction; holds at 2^CNT_W-1.

## Timing
- Reset (rst_n=0 at edge): out_valid=0, all out_* control/data=0, illegal_count=0. in_ready=1 on the first cycle after reset while flush=0.
- Latency 1: instruction accepted at edge N appears on out_* after edge N, i.e. in cycle N+1.
- Throughput 1/cycle while out_ready=1. On out_valid && !out_ready, all out_* hold stable and in_ready=0.
- Simultaneous consume and accept: the register reloads with the new entry; out_valid stays 1.
- flush: at the next edge out_valid<=0; no acceptance that cycle. Payload may remain but must not be relied on. Flush has priority over out_ready. The counter is unaffected by flush.
- Reset asserted mid-operation overrides flush and handshake; the in-flight entry is dropped.
- Counter saturation: at max value, an accepted illegal instruction leaves it unchanged.

## Test plan
- Reset, then add x1,x2,x3 (0x003100B3) with out_ready=1 -> next cycle out_valid=1, regwrite=1, aluop=10, alusrc=0, illegal=0, out_pc echoed.
- Stream lw, sw, beq, jal, lui, auipc back-to-back -> one output per cycle with the table values above, in order, no bubbles.
- out_ready=0 for 3 cycles with a valid entry held -> in_ready=0, out_* stable; release -> next instruction loaded on the same edge.
- jalr 0x000080E7 with ENABLE_JALR=1 -> jump=1, jalr=1, resultsrc=10; with ENABLE_JALR=0 -> illegal=1, all controls 0, count +1.
- mul 0x02208033: ENABLE_M=0 -> illegal=1, count +1; ENABLE_M=1 -> muldiv=1, regwrite=1, illegal=0.
- CNT_W=2, feed 5 instructions of 0x00000000 -> count 1,2,3,3,3. Flush while in_valid=1 -> in_ready=0, out_valid=0 next cycle, count unchanged.
